// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-channel mux.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel-id width; a single channel still needs a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer, grants the first requester at or after it.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int SEL_W = clog2_min1(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    input  logic [SEL_W-1:0] fb_idx,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] rr_ptr;
    logic             hit;

    // rr_ptr is always < N_CH, so one conditional subtract is enough to wrap.
    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= N_CH) ? s - N_CH : s;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!hit && req[wrap_idx(int'(rr_ptr), k)]) begin
                hit = 1'b1;
                grant[wrap_idx(int'(rr_ptr), k)] = 1'b1;
                grant_idx = SEL_W'(wrap_idx(int'(rr_ptr), k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= (int'(fb_idx) >= N_CH - 1) ? '0 : fb_idx + SEL_W'(1);
    end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel registered mux with valid/ready on every port; fixed-select or round-robin grant.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = clog2_min1(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic             can_load;
    logic             grant_ok;
    logic             xfer;
    logic             rr_adv;
    logic [SEL_W-1:0] g;
    logic [SEL_W-1:0] rr_idx;
    logic [N_CH-1:0]  rr_grant;
    logic [WIDTH-1:0] g_data;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (rr_adv),
        .fb_idx    (g),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    always_comb begin
        can_load = !out_valid || out_ready;
        if (mode == MODE_RR) begin
            g        = rr_idx;
            grant_ok = |rr_grant;
        end else begin
            g        = sel;
            grant_ok = int'(sel) < N_CH;
        end
        in_ready = '0;
        g_data   = '0;
        // An out-of-range sel matches no channel, leaving in_ready all low.
        for (int i = 0; i < N_CH; i++) begin
            if (int'(g) == i) begin
                g_data = in_data[i*WIDTH +: WIDTH];
                if (grant_ok && can_load && rst_n)
                    in_ready[i] = 1'b1;
            end
        end
        xfer   = |(in_valid & in_ready);
        rr_adv = xfer && (mode == MODE_RR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_ch    <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
